// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op codes, FSM encoding and operand-class predicates shared by muldiv_seq
package muldiv_pkg;
  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;
  typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_SIGN, ST_DONE} state_t;
  function automatic logic is_div(input logic [2:0] op);
    return op[2];
  endfunction
  function automatic logic is_signed_a(input logic [2:0] op);
    return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction
  function automatic logic is_signed_b(input logic [2:0] op);
    return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
  endfunction
endpackage

// File: rtl/muldiv_seq_hca32b.sv
// muldiv_seq_hca32b: 32-bit adder with carry in/out shared by the multiply and divide iterations
// ports: a, b operands; cin carry in; sum low 32 bits; cout carry out (33rd bit)
module muldiv_seq_hca32b (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {32'd0, cin};
endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative RV32M multiply/divide sequencer (32 iterations, start/busy/done handshake)
// ports: clk_i, rst_ni (sync active-low); start_i/op_i/rs1_i/rs2_i request; kill_i flush;
//        busy_o stall, done_o one-cycle result-valid pulse, result_o held until next accepted start
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic            kill_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);
  state_t          state;
  logic [4:0]      cnt;
  logic [2:0]      op;
  logic            sgn;
  logic [XLEN-1:0] hi, lo, b;
  logic            div_op, sa, sb, accept, fast, trial_ok, cout;
  logic [XLEN-1:0] fast_res, add_a, add_b, sum, word, sign_res;
  logic [2*XLEN-1:0] prod;
  assign busy_o   = state inside {ST_CALC, ST_SIGN};
  assign done_o   = state == ST_DONE;
  assign div_op   = is_div(op);
  assign sa       = is_signed_a(op_i) & rs1_i[XLEN-1];
  assign sb       = is_signed_b(op_i) & rs2_i[XLEN-1];
  assign accept   = start_i & ~busy_o;
  // divide by zero and signed overflow resolve without iterating
  assign fast     = is_div(op_i) & ((rs2_i == '0) |
                    (is_signed_b(op_i) & rs1_i == {1'b1, {(XLEN-1){1'b0}}} & rs2_i == '1));
  assign fast_res = rs2_i == '0 ? (op_i[1] ? rs1_i : '1) : (op_i[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}});
  // divide: {hi,lo} = {rem,quot} shifted left, subtract via ~b + 1; multiply: hi + (lo[0] ? b : 0)
  assign add_a    = div_op ? {hi[XLEN-2:0], lo[XLEN-1]} : hi;
  assign add_b    = div_op ? ~b : (lo[0] ? b : '0);
  // trial remainder is non-negative when the shifted-out bit or the carry covers the borrow
  assign trial_ok = hi[XLEN-1] | cout;
  muldiv_seq_hca32b hca32b (.a(add_a), .b(add_b), .cin(div_op), .sum(sum), .cout(cout));
  always_comb begin
    prod     = sgn ? ~{hi, lo} + 1'b1 : {hi, lo};
    word     = op[1] ? hi : lo;
    sign_res = div_op ? (sgn ? ~word + 1'b1 : word) : (op == OP_MUL ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      op       <= '0;
      sgn      <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      b        <= '0;
      result_o <= '0;
    end else if (kill_i) begin
      state <= ST_IDLE;
    end else if (accept) begin
      op    <= op_i;
      sgn   <= op_i == OP_REM ? sa : sa ^ sb;
      hi    <= '0;
      lo    <= sa ? -rs1_i : rs1_i;
      b     <= sb ? -rs2_i : rs2_i;
      cnt   <= '0;
      state <= fast ? ST_DONE : ST_CALC;
      if (fast) result_o <= fast_res;
    end else if (state == ST_CALC) begin
      hi    <= div_op ? (trial_ok ? sum : add_a) : {cout, sum[XLEN-1:1]};
      lo    <= div_op ? {lo[XLEN-2:0], trial_ok} : {sum[0], lo[XLEN-1:1]};
      cnt   <= cnt + 5'd1;
      state <= cnt == 5'd31 ? ST_SIGN : ST_CALC;
    end else if (state == ST_SIGN) begin
      result_o <= sign_res;
      state    <= ST_DONE;
    end else if (state == ST_DONE) begin
      state <= ST_IDLE;
    end
  end
endmodule
